// File: rtl/memstage_pkg.sv
// Memory stage shared definitions.
// FSM state encoding and default access timeout.
package memstage_pkg;

  localparam int MAX_WAIT_DEF = 15;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

endpackage

// File: rtl/memory_stage_wb_pipereg.sv
// M->W pipeline register for the memory stage.
// Loads a bubble while the stage is stalled.
module wb_pipereg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        abort,
  input  logic        reg_write,
  input  logic        pc_src,
  input  logic        mem_to_reg,
  input  logic [3:0]  write_addr,
  input  logic [31:0] rdata,
  input  logic [31:0] alu,
  output logic        reg_write_w,
  output logic        pc_src_w,
  output logic [3:0]  write_addr_w,
  output logic [31:0] result_w
);

  logic        mem_to_reg_q;
  logic [31:0] rdata_q;
  logic [31:0] alu_q;

  // Control bits: real instruction on advance, bubble on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_w <= 1'b0;
      pc_src_w    <= 1'b0;
    end else if (stall) begin
      reg_write_w <= 1'b0;
      pc_src_w    <= 1'b0;
    end else begin
      reg_write_w <= reg_write & ~(abort & mem_to_reg);
      pc_src_w    <= pc_src;
    end
  end

  // Data fields follow the instruction; aborted reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_addr_w <= '0;
      mem_to_reg_q <= 1'b0;
      rdata_q      <= '0;
      alu_q        <= '0;
    end else if (!stall) begin
      write_addr_w <= write_addr;
      mem_to_reg_q <= mem_to_reg;
      rdata_q      <= abort ? '0 : rdata;
      alu_q        <= alu;
    end
  end

  assign result_w = mem_to_reg_q ? rdata_q : alu_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory handshake,
// wait/timeout FSM and M->W register.
module memory_stage
  import memstage_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WriteAddrM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic [31:0] ALUResultM,
  output logic        StallM,
  output logic        BusErr,
  output logic        RegWriteW,
  output logic        PCSrcW,
  output logic [3:0]  WriteAddrW,
  output logic [31:0] ResultW
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          need;
  logic          abort;

  assign need  = MemtoRegM | MemWriteM;
  assign abort = (state == WAIT) & need
               & (cnt == CNT_MAX) & ~MemReady;

  assign MemReq   = reset & need & ~abort;
  assign StallM   = MemReq & ~MemReady;
  assign BusErr   = reset & abort;
  assign MemAddr  = ALUResultM;
  assign MemWData = WriteDataM;
  assign MemWe    = MemWriteM;

  // Access FSM: counter tracks cycles spent in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (need && !MemReady) begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        WAIT: begin
          if (!need || MemReady || abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // E->M ALU result, frozen while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
    end else if (!StallM) begin
      ALUResultM <= ALUResultE;
    end
  end

  wb_pipereg u_wb (
    .clk          (clk),
    .rst_n        (reset),
    .stall        (StallM),
    .abort        (abort),
    .reg_write    (RegWriteM),
    .pc_src       (PCSrcM),
    .mem_to_reg   (MemtoRegM),
    .write_addr   (WriteAddrM),
    .rdata        (MemRData),
    .alu          (ALUResultM),
    .reg_write_w  (RegWriteW),
    .pc_src_w     (PCSrcW),
    .write_addr_w (WriteAddrW),
    .result_w     (ResultW)
  );

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage.
// Instruction-level model plus literal pins.
module tb_memory_stage;

  localparam int MW = 15;

  logic        clk;
  logic        reset;
  logic        PCSrcM, RegWriteM;
  logic        MemtoRegM, MemWriteM;
  logic [31:0] ALUResultE, WriteDataM;
  logic [3:0]  WriteAddrM;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [31:0] MemRData;
  logic        MemReady;
  logic [31:0] ALUResultM;
  logic        StallM, BusErr;
  logic        RegWriteW, PCSrcW;
  logic [3:0]  WriteAddrW;
  logic [31:0] ResultW;

  memory_stage #(.MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUResultE (ALUResultE),
    .WriteDataM (WriteDataM),
    .WriteAddrM (WriteAddrM),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemRData   (MemRData),
    .MemReady   (MemReady),
    .ALUResultM (ALUResultM),
    .StallM     (StallM),
    .BusErr     (BusErr),
    .RegWriteW  (RegWriteW),
    .PCSrcW     (PCSrcW),
    .WriteAddrW (WriteAddrW),
    .ResultW    (ResultW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic        pcs;
    logic        m2r;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  waddr;
    int          lat;
  } instr_t;

  instr_t prog[$];

  int nvec;
  int nerr;
  int cyc;
  bit chk_en;

  logic        exp_req, exp_stall, exp_berr, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_alum;
  logic        w_rw, w_pcs, w_valid;
  logic [3:0]  w_addr;
  logic [31:0] w_res;

  int req_cnt, req_starts, stall_cnt, we_cnt;
  int berr_cnt, berr_cyc, rw_cnt, first_wb;
  logic        prev_req;
  logic [31:0] last_res;
  logic [3:0]  last_waddr;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h want %h",
               name, cyc, act, exp);
    end
  endtask

  function automatic instr_t nop_i();
    instr_t n;
    n.rw = 0; n.pcs = 0; n.m2r = 0; n.mw = 0;
    n.alu = '0; n.wdata = '0; n.rdata = '0;
    n.waddr = '0; n.lat = -1;
    return n;
  endfunction

  task automatic new_prog();
    prog.delete();
    prog.push_back(nop_i());
  endtask

  task automatic add(input logic rw, input logic pcs,
                     input logic m2r, input logic mw,
                     input logic [31:0] alu,
                     input logic [31:0] wdata,
                     input logic [3:0] waddr,
                     input logic [31:0] rdata,
                     input int lat);
    instr_t n;
    n.rw = rw; n.pcs = pcs; n.m2r = m2r; n.mw = mw;
    n.alu = alu; n.wdata = wdata; n.waddr = waddr;
    n.rdata = rdata; n.lat = lat;
    prog.push_back(n);
  endtask

  task automatic model_reset();
    exp_alum = '0;
    w_rw = 0; w_pcs = 0; w_addr = '0;
    w_res = '0; w_valid = 1;
  endtask

  // Runs prog through the M stage; called at posedge+1.
  task automatic run_seq(input int stop_at);
    int mi, age;
    instr_t cur, nxt;
    logic need, rdy, abt;
    mi = 0; age = 0; cyc = 0;
    req_cnt = 0; req_starts = 0; stall_cnt = 0;
    we_cnt = 0; berr_cnt = 0; berr_cyc = -1;
    rw_cnt = 0; first_wb = -1; prev_req = 0;
    last_res = '0; last_waddr = '0;
    while (mi < prog.size() + 2) begin
      if (stop_at >= 0 && cyc == stop_at) return;
      cur = nop_i();
      nxt = nop_i();
      if (mi < prog.size()) cur = prog[mi];
      if (mi + 1 < prog.size()) nxt = prog[mi+1];
      need = cur.m2r | cur.mw;
      rdy  = need && (cur.lat == age);
      abt  = need && !rdy && (age == MW);
      RegWriteM  = cur.rw;
      PCSrcM     = cur.pcs;
      MemtoRegM  = cur.m2r;
      MemWriteM  = cur.mw;
      WriteDataM = cur.wdata;
      WriteAddrM = cur.waddr;
      ALUResultE = nxt.alu;
      MemReady   = rdy;
      MemRData   = rdy ? cur.rdata : 32'hBAD0_0000 + age;
      exp_req   = need && !abt;
      exp_stall = exp_req && !rdy;
      exp_berr  = abt;
      exp_we    = cur.mw;
      exp_addr  = exp_alum;
      exp_wdata = cur.wdata;
      @(posedge clk);
      if (exp_stall) begin
        w_rw = 0; w_pcs = 0; w_valid = 0;
        age++;
      end else begin
        w_rw    = cur.rw & ~(abt & cur.m2r);
        w_pcs   = cur.pcs;
        w_addr  = cur.waddr;
        w_res   = cur.m2r ? (abt ? '0 : cur.rdata)
                          : exp_alum;
        w_valid = 1;
        exp_alum = nxt.alu;
        mi++;
        age = 0;
      end
      cyc++;
      #1;
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("MemReq", 32'(MemReq), 32'(exp_req));
        chk("StallM", 32'(StallM), 32'(exp_stall));
        chk("BusErr", 32'(BusErr), 32'(exp_berr));
        chk("MemWe", 32'(MemWe), 32'(exp_we));
        chk("MemAddr", MemAddr, exp_addr);
        chk("MemWData", MemWData, exp_wdata);
        chk("ALUResultM", ALUResultM, exp_alum);
        chk("RegWriteW", 32'(RegWriteW), 32'(w_rw));
        chk("PCSrcW", 32'(PCSrcW), 32'(w_pcs));
        if (w_valid) begin
          chk("WriteAddrW", 32'(WriteAddrW), 32'(w_addr));
          chk("ResultW", ResultW, w_res);
        end
        if (MemReq === 1'b1) begin
          req_cnt++;
          if (!prev_req) req_starts++;
          if (MemWe === 1'b1) we_cnt++;
        end
        prev_req = (MemReq === 1'b1);
        if (StallM === 1'b1) stall_cnt++;
        if (BusErr === 1'b1) begin
          berr_cnt++;
          berr_cyc = cyc;
        end
        if (RegWriteW === 1'b1) begin
          rw_cnt++;
          last_res   = ResultW;
          last_waddr = WriteAddrW;
          if (first_wb < 0) first_wb = cyc;
        end
      end
    end
  end

  initial begin
    nvec = 0; nerr = 0; cyc = 0; chk_en = 0;
    model_reset();
    exp_req = 0; exp_stall = 0; exp_berr = 0;
    exp_we = 0; exp_addr = '0; exp_wdata = '0;
    reset = 1'b0;
    RegWriteM = 1; PCSrcM = 1;
    MemtoRegM = 1; MemWriteM = 1;
    ALUResultE = 32'hFFFF_0000;
    WriteDataM = 32'h1; WriteAddrM = 4'hF;
    MemRData = '0; MemReady = 0;

    // Reset state with an access pending on the inputs
    #12;
    chk("rst_MemReq", 32'(MemReq), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_BusErr", 32'(BusErr), 32'd0);
    chk("rst_ALUResultM", ALUResultM, 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_PCSrcW", 32'(PCSrcW), 32'd0);
    chk("rst_ResultW", ResultW, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk_en = 1;

    // Plain ALU op
    new_prog();
    add(1, 0, 0, 0, 32'h1234, 0, 4'd3, 0, -1);
    run_seq(-1);
    chk("lit_alu_res", last_res, 32'h1234);
    chk("lit_alu_addr", 32'(last_waddr), 32'd3);
    chk("lit_alu_lat", 32'(first_wb), 32'd2);
    chk("lit_alu_stall", 32'(stall_cnt), 32'd0);

    // Zero-wait load
    new_prog();
    add(1, 0, 1, 0, 32'h100, 0, 4'd5, 32'hDEADBEEF, 0);
    run_seq(-1);
    chk("lit_ld0_res", last_res, 32'hDEADBEEF);
    chk("lit_ld0_lat", 32'(first_wb), 32'd2);
    chk("lit_ld0_stall", 32'(stall_cnt), 32'd0);

    // Store after an ALU op, ready after 3 wait cycles
    new_prog();
    add(1, 0, 0, 0, 32'h7, 0, 4'd1, 0, -1);
    add(0, 0, 0, 1, 32'h40, 32'hA5A5A5A5, 4'd0, 0, 3);
    run_seq(-1);
    chk("lit_st_req", 32'(req_cnt), 32'd4);
    chk("lit_st_we", 32'(we_cnt), 32'd4);
    chk("lit_st_stall", 32'(stall_cnt), 32'd3);
    chk("lit_st_starts", 32'(req_starts), 32'd1);
    chk("lit_st_rw", 32'(rw_cnt), 32'd1);

    // Load that never completes
    new_prog();
    add(1, 0, 1, 0, 32'h80, 0, 4'd6, 32'h0, -1);
    run_seq(-1);
    chk("lit_ab_berr", 32'(berr_cnt), 32'd1);
    chk("lit_ab_cyc", 32'(berr_cyc), 32'd16);
    chk("lit_ab_stall", 32'(stall_cnt), 32'd15);
    chk("lit_ab_rw", 32'(rw_cnt), 32'd0);

    // Ready on the last allowed cycle
    new_prog();
    add(1, 0, 1, 0, 32'h84, 0, 4'd7, 32'hCAFEF00D, MW);
    run_seq(-1);
    chk("lit_edge_berr", 32'(berr_cnt), 32'd0);
    chk("lit_edge_req", 32'(req_cnt), 32'd16);
    chk("lit_edge_res", last_res, 32'hCAFEF00D);
    chk("lit_edge_lat", 32'(first_wb), 32'd17);

    // Mixed stream with branches and back-to-back accesses
    new_prog();
    add(1, 1, 0, 0, 32'h55, 0, 4'd2, 0, -1);
    add(1, 0, 1, 0, 32'h200, 0, 4'd4, 32'h11112222, 1);
    add(1, 0, 1, 0, 32'h204, 0, 4'd8, 32'h33334444, 2);
    add(0, 0, 0, 1, 32'h208, 32'h99, 4'd0, 0, 0);
    add(1, 0, 0, 0, 32'hABCD, 0, 4'd10, 0, -1);
    run_seq(-1);
    chk("lit_mix_rw", 32'(rw_cnt), 32'd4);
    chk("lit_mix_last", last_res, 32'hABCD);

    // Reset in the middle of a wait
    new_prog();
    add(1, 0, 1, 0, 32'h300, 0, 4'd11, 32'h0, -1);
    run_seq(6);
    chk_en = 0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_MemReq", 32'(MemReq), 32'd0);
    chk("midrst_StallM", 32'(StallM), 32'd0);
    chk("midrst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("midrst_BusErr", 32'(BusErr), 32'd0);
    chk("midrst_ALUResultM", ALUResultM, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    chk_en = 1;
    new_prog();
    add(1, 0, 1, 0, 32'h400, 0, 4'd9, 32'h12345678, 2);
    run_seq(-1);
    chk("lit_post_res", last_res, 32'h12345678);
    chk("lit_post_addr", 32'(last_waddr), 32'd9);
    chk("lit_post_lat", 32'(first_wb), 32'd4);
    chk("lit_post_berr", 32'(berr_cnt), 32'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, maximum cycles a data-memory access waits for MemReady before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 PCSrcM, RegWriteM, MemtoRegM, MemWriteM  in  1 each  M-aligned control from Exec (condition-qualified).
REQ-005 ALUResultE  in  32  E-stage ALU result, registered here.
REQ-006 WriteDataM  in  32  store data from Exec; WriteAddrM  in  4  destination register.
REQ-007 MemReq  out  1  data-memory request; MemWe  out  1  write enable; MemAddr  out  32; MemWData  out  32.
REQ-008 MemRData  in  32  read data; MemReady  in  1  access complete this cycle.
REQ-009 ALUResultM  out  32  registered ALU result (memory address and forwarding source).
REQ-010 StallM  out  1  freezes Exec and earlier stages while high.
REQ-011 BusErr  out  1  one-cycle pulse on access abort.
REQ-012 RegWriteW, PCSrcW  out  1 each; WriteAddrW  out  4; ResultW  out  32  writeback values (ResultW also feeds forwarding).

Function
REQ-013 ALUResultM SHALL load ALUResultE on each edge where StallM is low and hold while StallM is high.
REQ-014 MemAddr SHALL equal ALUResultM, MemWData SHALL equal WriteDataM, MemWe SHALL equal MemWriteM, all combinational.
REQ-015 FSM states SHALL be IDLE and WAIT only.
REQ-016 Access needed = MemtoRegM | MemWriteM; MemReq SHALL be high when access needed in IDLE or in WAIT, except the abort cycle.
REQ-017 StallM SHALL equal MemReq & ~MemReady.
REQ-018 IDLE with access needed and MemReady high: zero-wait completion, no stall, stay IDLE.
REQ-019 IDLE with access needed and MemReady low: go WAIT, wait counter = 1.
REQ-020 WAIT: counter increments each cycle; MemReady high -> completion, go IDLE, counter = 0.
REQ-021 WAIT with counter == MAX_WAIT and MemReady low: abort -- MemReq low, StallM low, BusErr high for that cycle, go IDLE, counter = 0.
REQ-022 Address, data and MemWe SHALL be stable for the whole request (guaranteed by StallM freezing upstream).
REQ-023 Each M instruction SHALL issue exactly one access; no re-issue after completion.
REQ-024 M->W register, on edges with StallM low: RegWriteW <= RegWriteM & ~(abort & MemtoRegM), PCSrcW <= PCSrcM, WriteAddrW <= WriteAddrM, read data <= (abort ? 0 : MemRData), ALU copy <= ALUResultM, MemtoRegW <= MemtoRegM.
REQ-025 On edges with StallM high, the W register SHALL load a bubble (RegWriteW = 0, PCSrcW = 0; data fields don't-care).
REQ-026 ResultW SHALL be registered read data when MemtoRegW is high, else registered ALU copy.
REQ-027 Writeback latency: one cycle after completion edge; non-memory instructions: one cycle in M, one in W.
REQ-028 Simultaneous MemReady and counter == MAX_WAIT SHALL count as completion, not abort.
REQ-029 Counter width SHALL be $clog2(MAX_WAIT+1) bits with no wrap below MAX_WAIT.

Reset
REQ-030 reset low SHALL immediately force IDLE, counter 0, ALUResultM 0, all W registers 0, BusErr 0.
REQ-031 MemReq and StallM SHALL be low while reset is low, including reset asserted mid-WAIT.
REQ-032 After reset release, first access starts in IDLE with no stale request.

Structure
REQ-033 State enum and MAX_WAIT default SHALL live in a shared package memstage_pkg.
REQ-034 The M->W register with bubble insertion SHALL be a sub-module wb_pipereg; FSM and counter stay in memory_stage.

Verification
REQ-035 ALU op (RegWriteM=1, ALUResultE=0x1234, WriteAddrM=3), no memory -> two edges later ResultW=0x1234, WriteAddrW=3, RegWriteW=1; StallM never high.
REQ-036 Load, MemReady same cycle, MemRData=0xDEADBEEF -> no stall; next edge ResultW=0xDEADBEEF, RegWriteW=1.
REQ-037 Store to 0x40, data 0xA5A5A5A5, MemReady after 3 cycles -> MemReq/MemWe high 4 cycles, StallM high 3, bubbles in W, address/data stable, one request only.
REQ-038 Load, MemReady never (MAX_WAIT=15) -> BusErr pulses on 15th WAIT cycle, StallM drops, RegWriteW=0 next edge.
REQ-039 MemReady on cycle 15 exactly -> completion, no BusErr, data written back.
REQ-040 reset driven low mid-WAIT -> MemReq, StallM, RegWriteW low immediately; after release, new load completes normally.
